// File: rtl/wr_guard_recovery_ctrl_if.sv
// Fault/recovery signal bundle between the write-side transaction manager and
// its recovery sequencer. slave = sequencer side, master = manager/software side.
interface wr_guard_recovery_ctrl_if #(
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned EvtCntWidth = 8
);
  logic                   timeout_i;
  logic                   unwanted_i;
  logic [IdWidth-1:0]     evt_id_i;
  logic                   w_inflight_i;
  logic                   irq_ack_i;
  logic                   auto_recover_i;
  logic                   admit_o;
  logic                   isolate_o;
  logic                   mgr_clear_o;
  logic                   irq_o;
  logic [IdWidth-1:0]     irq_id_o;
  logic [1:0]             irq_cause_o;
  logic [EvtCntWidth-1:0] evt_cnt_o;
  logic [2:0]             state_o;

  modport slave (
    input  timeout_i, unwanted_i, evt_id_i, w_inflight_i, irq_ack_i, auto_recover_i,
    output admit_o, isolate_o, mgr_clear_o, irq_o, irq_id_o, irq_cause_o, evt_cnt_o,
           state_o
  );

  modport master (
    output timeout_i, unwanted_i, evt_id_i, w_inflight_i, irq_ack_i, auto_recover_i,
    input  admit_o, isolate_o, mgr_clear_o, irq_o, irq_id_o, irq_cause_o, evt_cnt_o,
           state_o
  );
endinterface

// File: rtl/wr_guard_recovery_ctrl.sv
// Write-side recovery sequencer: blocks AW admission, isolates the slave port,
// drains W, flushes the manager, holds, then recovers. Optional DRAIN watchdog:
// define WR_GUARD_DRAIN_WDT_EN.
module wr_guard_recovery_ctrl #(
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HoldCycles  = 16,
  parameter int unsigned DrainLimit  = 256,
  parameter int unsigned EvtCntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  wr_guard_recovery_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    FLUSH    = 3'd2,
    HOLD     = 3'd3,
    WAIT_ACK = 3'd4
  } state_e;

  localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HoldCycles - 1);

  if (HoldCycles < 1 || DrainLimit < 1) begin : g_bad_param
    $error("wr_guard_recovery_ctrl: HoldCycles and DrainLimit must be >= 1");
  end

  state_e                 state_q, state_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   irq_q, irq_d;
  logic [IdWidth-1:0]     irq_id_q, irq_id_d;
  logic [1:0]             irq_cause_q, irq_cause_d;
  logic [EvtCntWidth-1:0] evt_cnt_q, evt_cnt_d;
  logic [1:0]             fault_vec;

`ifdef WR_GUARD_DRAIN_WDT_EN
  localparam int unsigned DrainW = (DrainLimit > 1) ? $clog2(DrainLimit) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainLimit - 1);

  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              drain_forced_q, drain_forced_d;
`endif

  assign fault_vec = {bus.unwanted_i, bus.timeout_i};

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    irq_d       = irq_q;
    irq_id_d    = irq_id_q;
    irq_cause_d = irq_cause_q;
    evt_cnt_d   = evt_cnt_q;
`ifdef WR_GUARD_DRAIN_WDT_EN
    drain_cnt_d    = drain_cnt_q;
    drain_forced_d = drain_forced_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (|fault_vec) begin
          state_d     = DRAIN;
          irq_d       = 1'b1;
          irq_id_d    = bus.evt_id_i;
          irq_cause_d = fault_vec;
          if (evt_cnt_q != '1) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
          end
`ifdef WR_GUARD_DRAIN_WDT_EN
          drain_cnt_d = '0;
`endif
        end
      end

      DRAIN: begin
        // Later faults only widen the cause; the ID stays that of the first event.
        irq_cause_d = irq_cause_q | fault_vec;
        if (!bus.w_inflight_i) begin
          state_d = FLUSH;
`ifdef WR_GUARD_DRAIN_WDT_EN
        end else if (drain_cnt_q == DrainLast) begin
          state_d        = FLUSH;
          drain_forced_d = 1'b1;
          irq_cause_d    = 2'b11;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
`endif
        end
      end

      FLUSH: begin
        state_d    = HOLD;
        hold_cnt_d = HoldLoad;
      end

      HOLD: begin
        if (hold_cnt_q == '0) begin
          if (bus.auto_recover_i) begin
            state_d = IDLE;
            irq_d   = 1'b0;
`ifdef WR_GUARD_DRAIN_WDT_EN
            drain_forced_d = 1'b0;
`endif
          end else begin
            state_d = WAIT_ACK;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      WAIT_ACK: begin
        // Faults are not looked at here, so an ack coincident with a fault wins.
        if (bus.irq_ack_i) begin
          state_d = IDLE;
          irq_d   = 1'b0;
`ifdef WR_GUARD_DRAIN_WDT_EN
          drain_forced_d = 1'b0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase

`ifdef WR_GUARD_DRAIN_WDT_EN
    if (drain_forced_d) begin
      irq_cause_d = 2'b11;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= '0;
      irq_cause_q <= '0;
      evt_cnt_q   <= '0;
`ifdef WR_GUARD_DRAIN_WDT_EN
      drain_cnt_q    <= '0;
      drain_forced_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
      irq_cause_q <= irq_cause_d;
      evt_cnt_q   <= evt_cnt_d;
`ifdef WR_GUARD_DRAIN_WDT_EN
      drain_cnt_q    <= drain_cnt_d;
      drain_forced_q <= drain_forced_d;
`endif
    end
  end

  assign bus.admit_o     = (state_q == IDLE);
  assign bus.isolate_o   = (state_q == DRAIN) || (state_q == FLUSH) || (state_q == HOLD);
  assign bus.mgr_clear_o = (state_q == FLUSH);
  assign bus.irq_o       = irq_q;
  assign bus.irq_id_o    = irq_id_q;
  assign bus.irq_cause_o = irq_cause_q;
  assign bus.evt_cnt_o   = evt_cnt_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_wr_guard_recovery_ctrl.sv
// Directed bench for wr_guard_recovery_ctrl; the watchdog scenario follows
// whether WR_GUARD_DRAIN_WDT_EN is defined.
module tb_wr_guard_recovery_ctrl;

  localparam int unsigned IdW      = 4;
  localparam int unsigned EvtW     = 8;
  localparam int unsigned Hold     = 16;
  localparam int unsigned DrainLim = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wr_guard_recovery_ctrl_if #(.IdWidth(IdW), .EvtCntWidth(EvtW)) bus ();

  wr_guard_recovery_ctrl #(
    .IdWidth(IdW), .HoldCycles(Hold), .DrainLimit(DrainLim), .EvtCntWidth(EvtW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned clr_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.mgr_clear_o) clr_cnt++;
  endtask

  task automatic idle_inputs();
    bus.timeout_i = 0; bus.unwanted_i = 0; bus.evt_id_i = '0;
    bus.w_inflight_i = 0; bus.irq_ack_i = 0; bus.auto_recover_i = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step(); rst = 0;
    clr_cnt = 0;
  endtask

  task automatic wait_idle(output int unsigned n);
    n = 0;
    while (bus.state_o != 3'd0 && n < 100) begin n++; step(); end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) step();
    n_cmp++; if (bus.admit_o !== 1'b1) begin n_err++; $display("FAIL rst_admit: got %b want 1", bus.admit_o); end
    n_cmp++; if (bus.isolate_o !== 1'b0) begin n_err++; $display("FAIL rst_isolate: got %b want 0", bus.isolate_o); end
    n_cmp++; if (bus.irq_o !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", bus.irq_o); end
    n_cmp++; if (bus.evt_cnt_o !== 8'd0) begin n_err++; $display("FAIL rst_evt_cnt: got %0d want 0", bus.evt_cnt_o); end
    n_cmp++; if (bus.state_o !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.state_o); end
    n_cmp++; if (bus.mgr_clear_o !== 1'b0) begin n_err++; $display("FAIL rst_clear: got %b want 0", bus.mgr_clear_o); end
    n_cmp++; if (bus.irq_cause_o !== 2'b00) begin n_err++; $display("FAIL rst_cause: got %b want 00", bus.irq_cause_o); end
  endtask

  task automatic test_auto_recover();
    int unsigned hold_n;
    do_reset();
    bus.auto_recover_i = 1; bus.timeout_i = 1; bus.evt_id_i = 4'h5;
    step();
    bus.timeout_i = 0; bus.evt_id_i = 4'h0;
    n_cmp++; if (bus.state_o !== 3'd1) begin n_err++; $display("FAIL auto_drain_state: got %0d want 1", bus.state_o); end
    n_cmp++; if (bus.irq_o !== 1'b1) begin n_err++; $display("FAIL auto_irq_set: got %b want 1", bus.irq_o); end
    n_cmp++; if ({bus.admit_o, bus.isolate_o} !== 2'b01) begin n_err++; $display("FAIL auto_drain_gate: got %b want 01", {bus.admit_o, bus.isolate_o}); end
    step();
    n_cmp++; if (bus.state_o !== 3'd2 || bus.mgr_clear_o !== 1'b1) begin n_err++; $display("FAIL auto_flush: got state %0d clear %b want 2/1", bus.state_o, bus.mgr_clear_o); end
    step();
    hold_n = 0;
    while (bus.state_o == 3'd3 && hold_n < 40) begin hold_n++; step(); end
    n_cmp++; if (hold_n !== 16) begin n_err++; $display("FAIL auto_hold_len: got %0d want 16", hold_n); end
    n_cmp++; if (bus.state_o !== 3'd0 || bus.admit_o !== 1'b1) begin n_err++; $display("FAIL auto_idle: got state %0d admit %b want 0/1", bus.state_o, bus.admit_o); end
    n_cmp++; if (bus.irq_o !== 1'b0) begin n_err++; $display("FAIL auto_irq_clr: got %b want 0", bus.irq_o); end
    n_cmp++; if (bus.irq_id_o !== 4'h5) begin n_err++; $display("FAIL auto_id: got %0h want 5", bus.irq_id_o); end
    n_cmp++; if (bus.irq_cause_o !== 2'b01) begin n_err++; $display("FAIL auto_cause: got %b want 01", bus.irq_cause_o); end
    n_cmp++; if (bus.evt_cnt_o !== 8'd1) begin n_err++; $display("FAIL auto_evt_cnt: got %0d want 1", bus.evt_cnt_o); end
    n_cmp++; if (clr_cnt !== 1) begin n_err++; $display("FAIL auto_clear_pulses: got %0d want 1", clr_cnt); end
  endtask

  task automatic test_drain_wait();
    int unsigned n;
    bit bad;
    do_reset();
    bus.auto_recover_i = 1; bus.w_inflight_i = 1; bus.unwanted_i = 1; bus.evt_id_i = 4'h9;
    step();
    bus.unwanted_i = 0; bus.timeout_i = 1; bus.evt_id_i = 4'h3;
    n_cmp++; if (bus.irq_cause_o !== 2'b10) begin n_err++; $display("FAIL drain_cause0: got %b want 10", bus.irq_cause_o); end
    bad = 0;
    repeat (7) begin
      step();
      if (bus.state_o != 3'd1 || bus.mgr_clear_o) bad = 1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL drain_held: got early exit %b want 0", bad); end
    bus.w_inflight_i = 0; bus.timeout_i = 0;
    step();
    n_cmp++; if (bus.state_o !== 3'd2 || bus.mgr_clear_o !== 1'b1) begin n_err++; $display("FAIL drain_flush: got state %0d clear %b want 2/1", bus.state_o, bus.mgr_clear_o); end
    n_cmp++; if (bus.irq_cause_o !== 2'b11) begin n_err++; $display("FAIL drain_cause: got %b want 11", bus.irq_cause_o); end
    n_cmp++; if (bus.irq_id_o !== 4'h9) begin n_err++; $display("FAIL drain_id: got %0h want 9", bus.irq_id_o); end
    wait_idle(n);
    n_cmp++; if (bus.state_o !== 3'd0 || clr_cnt !== 1) begin n_err++; $display("FAIL drain_end: got state %0d pulses %0d want 0/1", bus.state_o, clr_cnt); end
  endtask

  task automatic test_manual_ack();
    int unsigned n;
    do_reset();
    bus.auto_recover_i = 0; bus.timeout_i = 1; bus.evt_id_i = 4'hA;
    step();
    bus.timeout_i = 0;
    step(); step(); step(); step();
    bus.irq_ack_i = 1; step(); bus.irq_ack_i = 0;
    n_cmp++; if (bus.state_o !== 3'd3) begin n_err++; $display("FAIL ack_in_hold: got state %0d want 3", bus.state_o); end
    n = 0;
    while (bus.state_o == 3'd3 && n < 40) begin n++; step(); end
    n_cmp++; if (bus.state_o !== 3'd4) begin n_err++; $display("FAIL ack_wait_state: got %0d want 4", bus.state_o); end
    n_cmp++; if ({bus.admit_o, bus.isolate_o, bus.irq_o} !== 3'b001) begin n_err++; $display("FAIL ack_wait_outs: got %b want 001", {bus.admit_o, bus.isolate_o, bus.irq_o}); end
    repeat (3) step();
    n_cmp++; if (bus.state_o !== 3'd4) begin n_err++; $display("FAIL ack_wait_stay: got %0d want 4", bus.state_o); end
    bus.irq_ack_i = 1; bus.timeout_i = 1; bus.evt_id_i = 4'hC;
    step();
    bus.irq_ack_i = 0;
    n_cmp++; if (bus.state_o !== 3'd0 || bus.irq_o !== 1'b0) begin n_err++; $display("FAIL ack_release: got state %0d irq %b want 0/0", bus.state_o, bus.irq_o); end
    step();
    bus.timeout_i = 0;
    n_cmp++; if (bus.state_o !== 3'd1 || bus.evt_cnt_o !== 8'd2 || bus.irq_id_o !== 4'hC) begin n_err++; $display("FAIL ack_refault: got state %0d cnt %0d id %0h want 1/2/c", bus.state_o, bus.evt_cnt_o, bus.irq_id_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.auto_recover_i = 1; bus.timeout_i = 1; bus.evt_id_i = 4'h7;
    step();
    bus.timeout_i = 0;
    step(); step(); step(); step();
    n_cmp++; if (bus.state_o !== 3'd3) begin n_err++; $display("FAIL mrst_pre: got state %0d want 3", bus.state_o); end
    rst = 1; step(); rst = 0;
    n_cmp++; if (bus.state_o !== 3'd0 || bus.admit_o !== 1'b1 || bus.isolate_o !== 1'b0 || bus.mgr_clear_o !== 1'b0) begin n_err++; $display("FAIL mrst_state: got state %0d admit %b iso %b clr %b want 0/1/0/0", bus.state_o, bus.admit_o, bus.isolate_o, bus.mgr_clear_o); end
    n_cmp++; if ({bus.irq_o, bus.irq_id_o, bus.irq_cause_o, bus.evt_cnt_o} !== '0) begin n_err++; $display("FAIL mrst_regs: got irq %b id %0h cause %b cnt %0d want zeros", bus.irq_o, bus.irq_id_o, bus.irq_cause_o, bus.evt_cnt_o); end
    repeat (20) step();
    n_cmp++; if (clr_cnt !== 1 || bus.state_o !== 3'd0) begin n_err++; $display("FAIL mrst_no_flush: got pulses %0d state %0d want 1/0", clr_cnt, bus.state_o); end
  endtask

  task automatic test_drain_watchdog();
    int unsigned n;
    do_reset();
    bus.auto_recover_i = 1; bus.w_inflight_i = 1; bus.unwanted_i = 1; bus.evt_id_i = 4'h2;
    step();
    bus.unwanted_i = 0;
`ifdef WR_GUARD_DRAIN_WDT_EN
    n = 0;
    while (bus.state_o == 3'd1 && n < 50) begin n++; step(); end
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL wdt_drain_len: got %0d want 8", n); end
    n_cmp++; if (bus.state_o !== 3'd2 || bus.mgr_clear_o !== 1'b1) begin n_err++; $display("FAIL wdt_flush: got state %0d clear %b want 2/1", bus.state_o, bus.mgr_clear_o); end
    n_cmp++; if (bus.irq_cause_o !== 2'b11) begin n_err++; $display("FAIL wdt_cause: got %b want 11", bus.irq_cause_o); end
`else
    n = 0;
    repeat (1000) begin
      step();
      if (bus.state_o != 3'd1) n++;
    end
    n_cmp++; if (n !== 0 || clr_cnt !== 0) begin n_err++; $display("FAIL nowdt_stuck: got %0d non-drain cycles %0d pulses want 0/0", n, clr_cnt); end
    n_cmp++; if (bus.irq_cause_o !== 2'b10) begin n_err++; $display("FAIL nowdt_cause: got %b want 10", bus.irq_cause_o); end
`endif
    bus.w_inflight_i = 0;
    wait_idle(n);
    n_cmp++; if (bus.state_o !== 3'd0) begin n_err++; $display("FAIL wdt_recover: got state %0d want 0", bus.state_o); end
  endtask

  task automatic test_evt_saturate();
    int unsigned n;
    int unsigned stuck;
    do_reset();
    bus.auto_recover_i = 1;
    stuck = 0;
    for (int i = 0; i < 300; i++) begin
      bus.timeout_i = 1; step(); bus.timeout_i = 0;
      wait_idle(n);
      if (bus.state_o != 3'd0) stuck++;
    end
    n_cmp++; if (stuck !== 0) begin n_err++; $display("FAIL sat_recover: got %0d stuck sequences want 0", stuck); end
    n_cmp++; if (bus.evt_cnt_o !== 8'd255) begin n_err++; $display("FAIL sat_evt_cnt: got %0d want 255", bus.evt_cnt_o); end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_auto_recover();
    test_drain_wait();
    test_manual_ack();
    test_mid_reset();
    test_drain_watchdog();
    test_evt_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
